// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] EBREAK_WORD     = 32'h0010_0073;
    localparam int          FETCH_BUF_DEPTH = 2;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry {pc, instr} FIFO with push, pop and flush
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_pc,
    input  logic [WIDTH-1:0] push_instr,
    output logic [1:0]       count,
    output logic             full,
    output logic [WIDTH-1:0] head_pc,
    output logic [WIDTH-1:0] head_instr
);

    localparam logic [1:0] DEPTH_CNT = 2'(FETCH_BUF_DEPTH);

    // Entry 0 is always the head; vacated entries are zeroed so an empty
    // head reads as zero without extra output muxing.
    logic [WIDTH-1:0] pc_q    [FETCH_BUF_DEPTH];
    logic [WIDTH-1:0] instr_q [FETCH_BUF_DEPTH];
    logic [WIDTH-1:0] pc_n    [FETCH_BUF_DEPTH];
    logic [WIDTH-1:0] instr_n [FETCH_BUF_DEPTH];
    logic [1:0]       count_q;
    logic [1:0]       count_n;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != DEPTH_CNT) || do_pop);

    // Next-state: flush wins, otherwise shift out the head then append.
    always_comb begin
        pc_n    = pc_q;
        instr_n = instr_q;
        count_n = count_q;
        if (flush) begin
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                pc_n[i]    = '0;
                instr_n[i] = '0;
            end
            count_n = 2'd0;
        end else begin
            if (do_pop) begin
                pc_n[0]    = pc_q[1];
                instr_n[0] = instr_q[1];
                pc_n[1]    = '0;
                instr_n[1] = '0;
                count_n    = count_q - 2'd1;
            end
            if (do_push) begin
                pc_n[count_n[0]]    = push_pc;
                instr_n[count_n[0]] = push_instr;
                count_n             = count_n + 2'd1;
            end
        end
    end

    // Storage registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            count_q <= 2'd0;
        end else begin
            pc_q    <= pc_n;
            instr_q <= instr_n;
            count_q <= count_n;
        end
    end

    assign count      = count_q;
    assign full       = (count_q == DEPTH_CNT);
    assign head_pc    = pc_q[0];
    assign head_instr = instr_q[0];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - IF-stage PC, fetch FSM and buffered decode handoff
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] imem_address,
    input  logic [WIDTH-1:0] imem_instruction,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instruction,
    output logic             halted
);

    logic [WIDTH-1:0] pc_q;
    fetch_state_t     state_q;
    logic             halted_q;
    logic [1:0]       buf_count;
    logic             buf_full;
    logic             pop_en;
    logic             push_en;
    logic             is_ebreak;
    logic [WIDTH-1:0] redirect_target;

    assign if_valid        = (buf_count != 2'd0);
    assign pop_en          = if_valid && if_ready;
    // A redirect discards both the pop and the push of its cycle.
    assign push_en         = (state_q == RUN) && !redirect_valid && (!buf_full || pop_en);
    assign is_ebreak       = (imem_instruction == WIDTH'(EBREAK_WORD));
    assign redirect_target = redirect_pc & ~WIDTH'(3);

    fetch_buffer #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push_en),
        .pop        (if_ready),
        .push_pc    (pc_q),
        .push_instr (imem_instruction),
        .count      (buf_count),
        .full       (buf_full),
        .head_pc    (if_pc),
        .head_instr (if_instruction)
    );

    // PC and fetch FSM; redirect has priority over every state transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            state_q  <= IDLE;
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q <= redirect_target;
            case (state_q)
                HALTED: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
                RUN:     if (!enable) state_q <= IDLE;
                default: state_q <= state_q;
            endcase
        end else begin
            case (state_q)
                IDLE: if (enable) state_q <= RUN;
                RUN: begin
                    if (push_en && is_ebreak) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        if (push_en) pc_q <= pc_q + WIDTH'(4);
                        if (!enable) state_q <= IDLE;
                    end
                end
                HALTED:  state_q <= HALTED;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_address = pc_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        halted;
    logic        ebreak_at_c;

    int          total;
    int          bad;
    logic [63:0] exp_q[$];
    logic [63:0] sb_e;

    fetch_sequencer #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .if_instruction   (if_instruction),
        .halted           (halted)
    );

    // Combinational instruction memory: address-derived words, optional EBREAK at 0xC.
    assign imem_instruction = (ebreak_at_c && imem_address == 32'hC) ? EBREAK
                                                                     : (32'hA000_0000 ^ imem_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        logic [31:0] w;
        w = (ebreak_at_c && a == 32'hC) ? EBREAK : (32'hA000_0000 ^ a);
        exp_q.push_back({a, w});
    endtask

    // Monitor: every completed handshake must match the next expected pair.
    always @(negedge clk) begin
        if (!reset && if_valid && if_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got pc %h expected no delivery", if_pc);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_pc", if_pc, sb_e[63:32]);
                chk("sb_instr", if_instruction, sb_e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        enable = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        ebreak_at_c = 1'b0;
        repeat (2) step();
        chk("rst_addr", imem_address, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instruction, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);

        // Streaming from reset with if_ready high
        push_exp(32'h0);
        push_exp(32'h4);
        reset = 1'b0;
        enable = 1'b1;
        if_ready = 1'b1;
        step();
        step(); chk("stream_pc0", if_pc, 32'h0);
        step(); chk("stream_pc4", if_pc, 32'h4);
        step(); chk("stream_pc8", if_pc, 32'h8);
        if_ready = 1'b0;

        // Backpressure: buffer saturates, then drains back-to-back
        reset = 1'b1;
        step();
        reset = 1'b0;
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        repeat (6) step();
        chk("bp_count", {30'h0, dut.buf_count}, 32'h2);
        chk("bp_pc", if_pc, 32'h0);
        chk("bp_addr", imem_address, 32'h8);
        if_ready = 1'b1;
        step(); chk("drain_pc4", if_pc, 32'h4);
        step(); chk("drain_pc8", if_pc, 32'h8);
        step();
        if_ready = 1'b0;

        // Redirect with full buffer and a same-cycle pop
        step();
        step();
        chk("pre_redir_count", {30'h0, dut.buf_count}, 32'h2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        if_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'h0, if_valid}, 32'h0);
        chk("redir_addr", imem_address, 32'h100);
        push_exp(32'h100);
        step(); chk("redir_pc", if_pc, 32'h100);
        step(); chk("redir_pc2", if_pc, 32'h104);
        if_ready = 1'b0;

        // EBREAK at 0xC halts fetching until a redirect
        ebreak_at_c = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        if_ready = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        push_exp(32'hC);
        repeat (4) step();
        chk("pre_halt", {31'h0, halted}, 32'h0);
        step();
        chk("halt_set", {31'h0, halted}, 32'h1);
        chk("halt_addr", imem_address, 32'hC);
        repeat (3) step();
        chk("halt_empty", {31'h0, if_valid}, 32'h0);
        chk("halt_addr2", imem_address, 32'hC);
        chk("halt_hold", {31'h0, halted}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        push_exp(32'h40);
        step();
        redirect_valid = 1'b0;
        chk("resume_halted", {31'h0, halted}, 32'h0);
        chk("resume_addr", imem_address, 32'h40);
        step(); chk("resume_pc", if_pc, 32'h40);
        step(); chk("resume_pc2", if_pc, 32'h44);
        if_ready = 1'b0;
        ebreak_at_c = 1'b0;

        // Asynchronous reset with a full buffer
        step();
        step();
        chk("pre_rst_count", {30'h0, dut.buf_count}, 32'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'h0, if_valid}, 32'h0);
        chk("arst_addr", imem_address, 32'h0);
        chk("arst_pc", if_pc, 32'h0);
        step();
        reset = 1'b0;
        if_ready = 1'b1;
        push_exp(32'h0);
        step();
        step(); chk("restart_pc0", if_pc, 32'h0);
        step(); chk("restart_pc4", if_pc, 32'h4);
        if_ready = 1'b0;

        // PC wraps modulo 2^32
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        if_ready = 1'b1;
        push_exp(32'hFFFF_FFFC);
        step();
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_address, 32'hFFFF_FFFC);
        step(); chk("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc_zero", if_pc, 32'h0);
        chk("wrap_addr2", imem_address, 32'h4);
        if_ready = 1'b0;
        step();
        step();
        chk("sb_drained", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the combinational instruction memory for the IF stage of the 5-stage RISC-V core. It owns the program counter, drives the memory address, and captures {pc, instruction} pairs into a 2-entry buffer. It presents those pairs to IF/ID with a valid/ready handshake. It applies branch/jump redirects from EX, which flush the buffer, and stops fetching when an EBREAK is fetched.

## Interface
- `WIDTH`, 32: address/instruction width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: level; fetching starts or continues only while high.
- `imem_address` out WIDTH: current PC; combinational from the PC register.
- `imem_instruction` in WIDTH: memory read data, valid in the same cycle as `imem_address`.
- `redirect_valid` in 1: one-cycle pulse from EX requesting a PC change.
- `redirect_pc` in WIDTH: redirect target; bits [1:0] are forced to 0.
- `if_valid` out 1: buffer head holds a valid instruction.
- `if_ready` in 1: decode accepts the head this cycle.
- `if_pc` out WIDTH: PC of the head entry.
- `if_instruction` out WIDTH: instruction of the head entry.
- `halted` out 1: high in the HALTED state.

## Operation
- States:
  - IDLE → RUN when `enable`=1.
  - RUN → IDLE when `enable`=0. The buffer is kept and may still drain.
  - RUN → HALTED when the pushed word equals EBREAK (32'h0010_0073).
  - HALTED → RUN on `redirect_valid`. Nothing else leaves HALTED except `reset`.
- Push: in RUN with no redirect, if count<2 or (count==2 and `if_valid`&`if_ready`), then:
  - push {pc, `imem_instruction`};
  - pc ← pc+4, wrapping modulo 2^WIDTH.
  - Otherwise pc holds and memory is re-read next cycle.
- Pop: `if_valid`&`if_ready` removes the head.
- Pushing and popping in the same cycle is legal at any count; count is unchanged.
- Redirect has top priority in every state:
  - buffer flushed (count←0);
  - the same-cycle pop and push are both discarded;
  - pc ← {`redirect_pc`[WIDTH-1:2], 2'b00}.
  - In IDLE, a redirect updates pc but stays in IDLE.
- EBREAK word: pushed normally; pc is not advanced afterwards.
- Reset mid-operation clears everything immediately. Buffer contents are lost and no handshake completes.

## Timing
- Reset values:
  - pc=`imem_address`=RESET_PC;
  - count=0, `if_valid`=0;
  - `if_pc`=0, `if_instruction`=0 (empty-entry outputs are forced to zero);
  - `halted`=0, state=IDLE.
- Fetch latency: the address is driven in cycle N and the pair is visible on `if_*` in cycle N+1.
- Redirect at edge N: the target address appears in cycle N+1 and the target instruction has `if_valid`=1 in cycle N+2.
- Sustained throughput is 1 instruction/cycle with `if_ready` held high.
- `if_*` outputs come from registers. `if_valid`, `if_pc` and `if_instruction` must stay stable while `if_valid`&!`if_ready`.
- `halted` rises the cycle after the EBREAK push edge.
- `enable` deassertion takes effect at the next edge.

## Structure
- Shared package `fetch_pkg`:
  - state enum {IDLE, RUN, HALTED};
  - `EBREAK_WORD` constant;
  - `FETCH_BUF_DEPTH`=2.
- Sub-module `fetch_buffer`:
  - 2-entry FIFO of {pc, instr} with push, pop and flush;
  - flush overrides push and pop;
  - exposes count, head and full.
- The top level holds the PC register, the FSM and the push-enable logic, and instantiates the instruction memory externally.

## Test plan
- Reset, then `enable`=1 and `if_ready`=1: `if_pc` sequence 0x0, 0x4, 0x8 on consecutive cycles, with matching memory words.
- Hold `if_ready`=0 for 5 cycles: count saturates at 2, `if_pc` stays 0x0, and `imem_address` holds 0x8.
  - Release: 0x0, 0x4, 0x8 delivered back-to-back with no gap or duplicate.
- Redirect to 0x103 with the buffer full and `if_ready`=1 in the same cycle:
  - next cycle `if_valid`=0 and `imem_address`=0x100;
  - the cycle after, `if_pc`=0x100.
  - The popped entry does not count as delivered.
- EBREAK stored at 0xC: `halted`=1 after 0xC is pushed, `imem_address` stays 0xC, and 0x10 is never enqueued.
  - A redirect to 0x40 resumes fetching with `halted`=0.
- Assert `reset` mid-stream with count=2: `if_valid`=0 and `imem_address`=RESET_PC immediately, asynchronously.
  - After release with `enable`=1, fetching restarts at RESET_PC.
- PC wrap: redirect to 0xFFFF_FFFC gives the next `if_pc` sequence 0xFFFF_FFFC, 0x0000_0000.
